ram64_reader: RTL

RAM64_READER -- requirements
Module: ram64_reader

---
 rtl/ram64_pkg.sv | 9 +
 rtl/reader_fifo2.sv | 36 +++
 rtl/ram64_reader.sv | 65 ++++++
 3 files changed

// File: rtl/ram64_pkg.sv
// ram64_pkg: shared widths, buffer depth and FSM state encoding for the RAM64 burst reader
package ram64_pkg;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/reader_fifo2.sv
// reader_fifo2: 2-entry output buffer; ports clk/rst (async active-low), push/wdata in, pop, flush, head/count out
module reader_fifo2
  import ram64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic rd, wr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= wdata;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign head = mem[rd];
endmodule

// File: rtl/ram64_reader.sv
// ram64_reader: streams a burst of RAM64 words (base_addr, length 0=64) through a 2-entry buffer; clk, rst (async active-low), start/abort in, mem_addr/mem_we/mem_rdata to RAM, out_data/out_valid/out_ready stream, busy/done status
module ram64_reader
  import ram64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  logic [1:0]      state;
  logic [ADDR_W:0] remaining;
  logic [1:0]      count;
  logic            pop, push, flush;
  assign pop       = out_valid && out_ready;
  // a full buffer still has room when its head leaves in the same cycle
  assign push      = state == READ && !abort && (count < 2'd2 || pop);
  assign flush     = abort && state != IDLE;
  assign done      = state == DRAIN && count == 2'd0 && !abort;
  assign out_valid = count != 2'd0;
  assign busy      = state != IDLE;
  assign mem_we    = 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      remaining <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state     <= READ;
        mem_addr  <= base_addr;
        remaining <= length == '0 ? 7'd64 : {1'b0, length};
      end
    end else if (abort) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (state == READ) begin
      if (push) begin
        mem_addr  <= mem_addr + ADDR_W'(1);
        remaining <= remaining - 7'd1;
        if (remaining == 7'd1) state <= DRAIN;
      end
    end else if (state != DRAIN || done) begin
      state <= IDLE;
    end
  reader_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (mem_rdata),
    .head  (out_data),
    .count (count)
  );
endmodule
